// File: rtl/mux153_sd1_unit.sv
// mux153_sd1_unit: registered 74HC153-style mux slice plus a majority (SD1) slice
// SD1 reuses the same mux function, with {a,b} as select and {1,c,c,0} as data
module mux153_sd1_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       e_n,
  input  logic [1:0] s,
  input  logic [3:0] i,
  output logic       y,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       sd1_y
);
  function automatic logic mux4(input logic en_n, input logic [1:0] sel, input logic [3:0] d);
    return en_n ? 1'b0 : d[sel];
  endfunction
  logic w_mux_next, w_sd1_next, r_y, r_sd1_y;
  assign w_mux_next = mux4(e_n, s, i);
  assign w_sd1_next = mux4(1'b0, {a, b}, {1'b1, c, c, 1'b0});
  always_ff @(posedge clk) begin
    r_y     <= rst ? 1'b0 : w_mux_next;
    r_sd1_y <= rst ? 1'b0 : w_sd1_next;
  end
  assign y     = r_y;
  assign sd1_y = r_sd1_y;
endmodule

// File: tb/tb_mux153_sd1_unit.sv
// tb_mux153_sd1_unit: directed self-checking bench for the registered mux and SD1 slices
module tb_mux153_sd1_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       e_n = 1'b0;
  logic [1:0] s = 2'd0;
  logic [3:0] i = 4'd0;
  logic       a = 1'b0, b = 1'b0, c = 1'b0;
  logic       y, sd1_y;
  int checks = 0;
  int errors = 0;

  mux153_sd1_unit dut (
    .clk(clk), .rst(rst), .e_n(e_n), .s(s), .i(i), .y(y),
    .a(a), .b(b), .c(c), .sd1_y(sd1_y)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; e_n = 1'b0; s = 2'd3; i = 4'hF; {a, b, c} = 3'b111;
    for (int n = 0; n < 2; n++) begin
      tick();
      checks++;
      if (y !== 1'b0) begin errors++; $display("FAIL reset_y cycle %0d: got %b want 0", n, y); end
      checks++;
      if (sd1_y !== 1'b0) begin errors++; $display("FAIL reset_sd1 cycle %0d: got %b want 0", n, sd1_y); end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (y !== 1'b1) begin errors++; $display("FAIL reset_release_y: got %b want 1", y); end
    checks++;
    if (sd1_y !== 1'b1) begin errors++; $display("FAIL reset_release_sd1: got %b want 1", sd1_y); end
  endtask

  task automatic test_mux_sweep();
    logic [3:0] pats [2] = '{4'b1010, 4'b0101};
    logic [3:0] exps [2] = '{4'b1010, 4'b0101};
    logic [3:0] ex;
    e_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      i = pats[p];
      ex = exps[p];
      for (int k = 0; k < 4; k++) begin
        s = k[1:0];
        tick();
        checks++;
        if (y !== ex[k]) begin errors++; $display("FAIL mux_sweep i=%b s=%0d: got %b want %b", i, k, y, ex[k]); end
      end
    end
  endtask

  task automatic test_disable();
    e_n = 1'b1; s = 2'd2; i = 4'hF;
    tick();
    checks++;
    if (y !== 1'b0) begin errors++; $display("FAIL disable_y: got %b want 0", y); end
    e_n = 1'b0;
    tick();
    checks++;
    if (y !== 1'b1) begin errors++; $display("FAIL enable_y: got %b want 1", y); end
    // X on unselected bits must not leak into y
    s = 2'd1; i = 4'bxx1x;
    tick();
    checks++;
    if (y !== 1'b1) begin errors++; $display("FAIL x_unselected_hi: got %b want 1", y); end
    s = 2'd2; i = 4'bx0xx;
    tick();
    checks++;
    if (y !== 1'b0) begin errors++; $display("FAIL x_unselected_lo: got %b want 0", y); end
    e_n = 1'b1; i = 4'bxxxx; s = 2'd3;
    tick();
    checks++;
    if (y !== 1'b0) begin errors++; $display("FAIL disable_x: got %b want 0", y); end
    e_n = 1'b0; i = 4'h0;
  endtask

  task automatic test_sd1();
    logic [2:0] seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    logic       exp [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 8; k++) begin
      {a, b, c} = seq[k];
      e_n = k[0];
      tick();
      checks++;
      if (sd1_y !== exp[k]) begin errors++; $display("FAIL sd1 abc=%b: got %b want %b", seq[k], sd1_y, exp[k]); end
    end
    e_n = 1'b0;
  endtask

  task automatic test_random_reset();
    logic ey, es;
    for (int n = 0; n < 20; n++) begin
      e_n = 1'b0;
      s = 2'($urandom_range(0, 3));
      i = 4'($urandom_range(0, 15));
      {a, b, c} = 3'($urandom_range(0, 7));
      rst = (n == 10);
      ey = rst ? 1'b0 : ((i >> s) & 4'd1) != 4'd0;
      es = rst ? 1'b0 : (a & b) | (a & c) | (b & c);
      tick();
      checks++;
      if (y !== ey) begin errors++; $display("FAIL random_y n=%0d s=%0d i=%b: got %b want %b", n, s, i, y, ey); end
      checks++;
      if (sd1_y !== es) begin errors++; $display("FAIL random_sd1 n=%0d abc=%b%b%b: got %b want %b", n, a, b, c, sd1_y, es); end
    end
    rst = 1'b0;
  endtask

  task automatic test_independence();
    {a, b, c} = 3'b110; s = 2'd1; i = 4'b0010;
    for (int n = 0; n < 6; n++) begin
      e_n = n[0];
      tick();
      checks++;
      if (sd1_y !== 1'b1) begin errors++; $display("FAIL indep_sd1 n=%0d: got %b want 1", n, sd1_y); end
      checks++;
      if (y !== ~n[0]) begin errors++; $display("FAIL indep_y n=%0d: got %b want %b", n, y, ~n[0]); end
    end
    e_n = 1'b0;
  endtask

  task automatic test_between_edges();
    e_n = 1'b0; s = 2'd0; i = 4'b0001;
    tick();
    #2 i = 4'b0000;
    #1;
    checks++;
    if (y !== 1'b1) begin errors++; $display("FAIL hold_between_edges: got %b want 1", y); end
    tick();
    checks++;
    if (y !== 1'b0) begin errors++; $display("FAIL update_next_edge: got %b want 0", y); end
  endtask

  initial begin
    test_reset();
    test_mux_sweep();
    test_disable();
    test_sd1();
    test_random_reset();
    test_independence();
    test_between_edges();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
